// File: rtl/axo_mem_sram_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : axo_mem_sram_resp_if
// Description : axo_mem_bus port bundle between an initiator and a responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface axo_mem_sram_resp_if #(
  parameter int unsigned ALEN = 32,
  parameter int unsigned DLEN = 32
);
  logic            re;
  logic            we;
  logic [1:0]      asize;
  logic [ALEN-1:0] addr;
  logic [DLEN-1:0] wdata;
  logic [DLEN-1:0] rdata;
  logic            ready;
  logic            error;

  modport master (
    output re, we, asize, addr, wdata,
    input  rdata, ready, error
  );

  modport slave (
    input  re, we, asize, addr, wdata,
    output rdata, ready, error
  );
endinterface
`default_nettype wire

// File: rtl/axo_mem_sram_resp.sv
`default_nettype none
// ============================================================================
// Module      : axo_mem_sram_resp
// Description : Single-port SRAM responder with fixed latency and error checks.
// Revision    : 1.0 - initial release
// ============================================================================
module axo_mem_sram_resp #(
  parameter int unsigned ALEN    = 32,
  parameter int unsigned DLEN    = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned BASE    = 0,
  parameter int unsigned LATENCY = 1
) (
  input wire                 clk,
  input wire                 rst_n,
  axo_mem_sram_resp_if.slave bus
);

  localparam int unsigned     AW     = $clog2(DEPTH);
  localparam logic [ALEN-1:0] C_BASE = ALEN'(BASE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            re_q, re_d;
  logic            we_q, we_d;
  logic [1:0]      asize_q, asize_d;
  logic [ALEN-1:0] addr_q, addr_d;
  logic [DLEN-1:0] wdata_q, wdata_d;
  logic            ready_q, ready_d;
  logic            error_q, error_d;
  logic [DLEN-1:0] rdata_q, rdata_d;

  logic [DLEN-1:0] mem [DEPTH];

  logic [AW-1:0]   idx;
  logic [4:0]      shamt;
  logic [DLEN-1:0] size_mask;
  logic            misaligned;
  logic            in_range;
  logic            req_err;
  logic [DLEN-1:0] rd_word;
  logic [DLEN-1:0] rd_val;
  logic [DLEN-1:0] wr_word;
  logic            mem_we;

  // Base is aligned to the array size, so the range check reduces to
  // matching the address bits above the word index.
  assign idx      = addr_q[AW+1:2];
  assign shamt    = {addr_q[1:0], 3'b000};
  assign in_range = (addr_q[ALEN-1:AW+2] == C_BASE[ALEN-1:AW+2]);

  always_comb begin
    size_mask  = '1;
    misaligned = 1'b0;
    case (asize_q)
      2'd0: size_mask = DLEN'(32'h0000_00ff);
      2'd1: begin
        size_mask  = DLEN'(32'h0000_ffff);
        misaligned = addr_q[0];
      end
      default: misaligned = |addr_q[1:0];
    endcase
  end

  assign req_err = (re_q & we_q) | (asize_q == 2'd3) | misaligned | ~in_range;
  assign rd_word = mem[idx];
  assign rd_val  = (rd_word >> shamt) & size_mask;
  assign wr_word = (rd_word & ~(size_mask << shamt)) | ((wdata_q & size_mask) << shamt);
  assign mem_we  = (state_q == S_RESP) & we_q & ~req_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    re_d    = re_q;
    we_d    = we_q;
    asize_d = asize_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.re | bus.we) begin
          re_d    = bus.re;
          we_d    = bus.we;
          asize_d = bus.asize;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        // Outputs are registered, so the pulse is seen in the cycle after this one.
        state_d = S_IDLE;
        ready_d = 1'b1;
        error_d = req_err;
        rdata_d = (req_err || !re_q) ? '0 : rd_val;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      asize_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      re_q    <= re_d;
      we_q    <= we_d;
      asize_q <= asize_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately outside the reset domain; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wr_word;
  end

  assign bus.ready = ready_q;
  assign bus.error = error_q;
  assign bus.rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_axo_mem_sram_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_axo_mem_sram_resp
// Description : Self-checking bench for axo_mem_sram_resp against a byte model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axo_mem_sram_resp;

  logic clk = 1'b0;
  logic rst_n0, rst_n1, rst_n2;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  axo_mem_sram_resp_if #(.ALEN(32), .DLEN(32)) bus0 ();
  axo_mem_sram_resp_if #(.ALEN(32), .DLEN(32)) bus1 ();
  axo_mem_sram_resp_if #(.ALEN(32), .DLEN(32)) bus2 ();

  axo_mem_sram_resp #(.ALEN(32), .DLEN(32), .DEPTH(256), .BASE(0), .LATENCY(1))
    u_dut_l1 (.clk(clk), .rst_n(rst_n0), .bus(bus0));
  axo_mem_sram_resp #(.ALEN(32), .DLEN(32), .DEPTH(256), .BASE(0), .LATENCY(4))
    u_dut_l4 (.clk(clk), .rst_n(rst_n1), .bus(bus1));
  axo_mem_sram_resp #(.ALEN(32), .DLEN(32), .DEPTH(64), .BASE(32'h400), .LATENCY(3))
    u_dut_l3 (.clk(clk), .rst_n(rst_n2), .bus(bus2));

  // Reference memory: one byte per address offset from each instance's base.
  logic [7:0] mdl [3][1024];

  function automatic int unsigned lat_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 4 : 3;
  endfunction
  function automatic int unsigned base_of(input int d);
    return (d == 2) ? 32'h400 : 0;
  endfunction
  function automatic int unsigned depth_of(input int d);
    return (d == 2) ? 64 : 256;
  endfunction

  function automatic bit model_err(input int d, input bit re, input bit we,
                                   input logic [1:0] asz, input logic [31:0] a);
    longint unsigned lo = base_of(d);
    longint unsigned hi = lo + 4 * depth_of(d);
    int unsigned     n  = 1 << asz;
    return (re && we) || (asz == 2'd3) || ((a % n) != 0) || (a < lo) || (a >= hi);
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [1:0] asz, input logic [31:0] a);
    logic [31:0] v   = '0;
    int unsigned off = a - base_of(d);
    for (int i = 0; i < (1 << asz); i++) v = v | (32'(mdl[d][off+i]) << (8 * i));
    return v;
  endfunction

  task automatic model_write(input int d, input logic [1:0] asz, input logic [31:0] a, input logic [31:0] wd);
    int unsigned off = a - base_of(d);
    for (int i = 0; i < (1 << asz); i++) mdl[d][off+i] = wd[8*i +: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input bit re, input bit we, input logic [1:0] asz,
                       input logic [31:0] a, input logic [31:0] wd);
    case (d)
      0: begin bus0.re = re; bus0.we = we; bus0.asize = asz; bus0.addr = a; bus0.wdata = wd; end
      1: begin bus1.re = re; bus1.we = we; bus1.asize = asz; bus1.addr = a; bus1.wdata = wd; end
      default: begin bus2.re = re; bus2.we = we; bus2.asize = asz; bus2.addr = a; bus2.wdata = wd; end
    endcase
  endtask

  function automatic logic get_ready(input int d);
    return (d == 0) ? bus0.ready : (d == 1) ? bus1.ready : bus2.ready;
  endfunction
  function automatic logic get_error(input int d);
    return (d == 0) ? bus0.error : (d == 1) ? bus1.error : bus2.error;
  endfunction
  function automatic logic [31:0] get_rdata(input int d);
    return (d == 0) ? bus0.rdata : (d == 1) ? bus1.rdata : bus2.rdata;
  endfunction

  // One transaction: issue, wait for ready (bounded), compare against the model.
  task automatic access(input int d, input bit re, input bit we, input logic [1:0] asz,
                        input logic [31:0] a, input logic [31:0] wd, input bit drop,
                        output logic [31:0] rd, output logic er);
    bit          exp_err;
    logic [31:0] exp_rd;
    int          k;
    bit          got;
    exp_err = model_err(d, re, we, asz, a);
    exp_rd  = (exp_err || !re) ? 32'h0 : model_read(d, asz, a);
    @(negedge clk);
    drive(d, re, we, asz, a, wd);
    @(posedge clk); #1;
    if (drop) drive(d, 1'b0, 1'b0, 2'($urandom), $urandom, $urandom);
    got = 1'b0;
    k   = 0;
    while (!got && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (get_ready(d)) got = 1'b1;
    end
    if (!got) chk("ready timeout", 32'd0, 32'd1);
    else      chk("latency", k, lat_of(d));
    rd = get_rdata(d);
    er = get_error(d);
    drive(d, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk("error", {31'd0, er}, {31'd0, exp_err});
    if (exp_err || (re && !we)) chk("rdata", rd, exp_rd);
    if (!exp_err && we) model_write(d, asz, a, wd);
    @(posedge clk); #1;
    chk("ready pulse width", {31'd0, get_ready(d)}, 32'd0);
    chk("error outside ready", {31'd0, get_error(d)}, 32'd0);
  endtask

  task automatic rand_op(input int d);
    bit          re, we;
    logic [1:0]  asz;
    logic [31:0] a, wd, rd;
    logic        er;
    int          r;
    r   = $urandom_range(0, 19);
    re  = (r < 10) || (r == 19);
    we  = (r >= 10);
    asz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    a   = base_of(d) + $urandom_range(0, 4 * depth_of(d) - 1);
    if ($urandom_range(0, 5) != 0) a = a & ~32'((1 << asz) - 1);
    r = $urandom_range(0, 15);
    if (r == 0) a = base_of(d) + 4 * depth_of(d) + 4 * $urandom_range(0, 15);
    else if (r == 1 && base_of(d) != 0) a = 4 * $urandom_range(0, base_of(d) / 4 - 1);
    wd = $urandom;
    access(d, re, we, asz, a, wd, 1'b0, rd, er);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, pre, a;
    logic        er;
    int          idx;
    bit          seen;

    drive(0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    drive(2, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    rst_n0 = 1'b1; rst_n1 = 1'b1; rst_n2 = 1'b1;
    #2;
    rst_n0 = 1'b0; rst_n1 = 1'b0; rst_n2 = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset ready", {31'd0, get_ready(d)}, 32'd0);
      chk("reset error", {31'd0, get_error(d)}, 32'd0);
      chk("reset rdata", get_rdata(d), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n0 = 1'b1; rst_n1 = 1'b1; rst_n2 = 1'b1;

    // Give every word a known nonzero value so later reads are defined.
    for (int w = 0; w < 256; w++) access(0, 1'b0, 1'b1, 2'd2, 4 * w, $urandom | 32'h1, 1'b0, rd, er);
    for (int w = 0; w < 64; w++)  access(2, 1'b0, 1'b1, 2'd2, 32'h400 + 4 * w, $urandom | 32'h1, 1'b0, rd, er);
    for (int w = 0; w < 16; w++)  access(1, 1'b0, 1'b1, 2'd2, 4 * w, $urandom | 32'h1, 1'b0, rd, er);

    // Word write/read.
    access(0, 1'b0, 1'b1, 2'd2, 32'd8, 32'hcafebabe, 1'b0, rd, er);
    access(0, 1'b1, 1'b0, 2'd2, 32'd8, 32'h0, 1'b0, rd, er);
    chk("word readback", rd, 32'hcafebabe);

    // Byte and half lanes.
    access(0, 1'b0, 1'b1, 2'd2, 32'd0, 32'h00000000, 1'b0, rd, er);
    access(0, 1'b0, 1'b1, 2'd0, 32'd1, 32'h123456ef, 1'b0, rd, er);
    access(0, 1'b1, 1'b0, 2'd2, 32'd0, 32'h0, 1'b0, rd, er);
    chk("byte lane 1", rd, 32'h0000ef00);
    access(0, 1'b0, 1'b1, 2'd1, 32'd2, 32'h9999beef, 1'b0, rd, er);
    access(0, 1'b1, 1'b0, 2'd2, 32'd0, 32'h0, 1'b0, rd, er);
    chk("half lane 2", rd, 32'hbeefef00);
    access(0, 1'b1, 1'b0, 2'd0, 32'd3, 32'h0, 1'b0, rd, er);
    chk("byte read lane 3", rd, 32'h000000be);

    // Error cases.
    access(0, 1'b1, 1'b0, 2'd1, 32'd1, 32'h0, 1'b0, rd, er);
    chk("misaligned half error", {31'd0, er}, 32'd1);
    chk("misaligned half rdata", rd, 32'd0);
    access(0, 1'b1, 1'b0, 2'd3, 32'd0, 32'h0, 1'b0, rd, er);
    chk("asize3 error", {31'd0, er}, 32'd1);
    access(0, 1'b1, 1'b1, 2'd2, 32'd0, 32'h0, 1'b0, rd, er);
    chk("re and we error", {31'd0, er}, 32'd1);
    access(0, 1'b1, 1'b0, 2'd2, 32'd1024, 32'h0, 1'b0, rd, er);
    chk("end of range error", {31'd0, er}, 32'd1);
    access(0, 1'b0, 1'b1, 2'd2, 32'd2, 32'hdeadbeef, 1'b0, rd, er);
    chk("faulting write error", {31'd0, er}, 32'd1);
    access(0, 1'b1, 1'b0, 2'd2, 32'd0, 32'h0, 1'b0, rd, er);
    chk("faulting write no effect", rd, 32'hbeefef00);
    access(2, 1'b1, 1'b0, 2'd2, 32'h3fc, 32'h0, 1'b0, rd, er);
    chk("below base error", {31'd0, er}, 32'd1);

    // Back-to-back reads with the request held, address stepped on ready.
    a = 32'd0;
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 2'd2, a, 32'd0);
    @(posedge clk); #1;
    idx = 0;
    for (int c = 1; c <= 45 && idx < 8; c++) begin
      @(posedge clk); #1;
      if (get_ready(1)) begin
        chk("throughput ready cycle", c, 4 + 5 * idx);
        chk("throughput rdata", get_rdata(1), model_read(1, 2'd2, 4 * idx));
        idx++;
        a = 4 * idx;
        drive(1, 1'b1, 1'b0, 2'd2, a, 32'd0);
      end
    end
    drive(1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk("throughput count", idx, 32'd8);
    repeat (6) @(posedge clk);

    // Request dropped after one cycle still completes and commits.
    access(2, 1'b0, 1'b1, 2'd2, 32'h410, 32'h5a5aa5a5, 1'b1, rd, er);
    access(2, 1'b1, 1'b0, 2'd2, 32'h410, 32'h0, 1'b0, rd, er);
    chk("dropped write visible", rd, 32'h5a5aa5a5);

    // Reset during the wait phase of a write aborts it.
    access(2, 1'b1, 1'b0, 2'd2, 32'h408, 32'h0, 1'b0, rd, er);
    pre = rd;
    @(negedge clk);
    drive(2, 1'b0, 1'b1, 2'd2, 32'h408, ~pre);
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst_n2 = 1'b0;
    #1;
    chk("midop reset ready", {31'd0, get_ready(2)}, 32'd0);
    chk("midop reset error", {31'd0, get_error(2)}, 32'd0);
    chk("midop reset rdata", get_rdata(2), 32'd0);
    @(negedge clk);
    rst_n2 = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (get_ready(2)) seen = 1'b1;
    end
    chk("no ready after abort", {31'd0, seen}, 32'd0);
    access(2, 1'b1, 1'b0, 2'd2, 32'h408, 32'h0, 1'b0, rd, er);
    chk("aborted write not committed", rd, pre);

    // Randomized traffic against the byte model.
    for (int i = 0; i < 150; i++) rand_op(0);
    for (int i = 0; i < 40; i++)  rand_op(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
